sr_cmd_gen: RTL and testbench

- Upstream command stage for the gated SR latch.
- Takes two raw, asynchronous request lines (set, clear) and synchronizes and debounces them.
- Arbitrates the two requests and issues clean, fixed-width s/r pulses aligned to clk.
- Guarantees that s and r are never asserted together, so the downstream latch never sees the 2'b11 (x) combination.

---
 rtl/sr_cmd_gen.sv | 170 +++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// ----------------------------------------------------------------------------
// sr_cmd_gen : sync/debounce/arbitrate set+clear requests into s/r pulses. Rev 1.0
// Optional macro SR_STATE_TRACK_EN: drop commands that would not change the latch.
// ----------------------------------------------------------------------------
`default_nettype none

module sr_cmd_gen #(
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_W    = 2,
   parameter int GUARD      = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_in,
   input  logic clr_in,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   localparam logic [7:0] C_DEB        = 8'(DEB_CYCLES);
   localparam logic [3:0] C_PULSE_LAST = 4'(PULSE_W - 1);
   localparam logic [3:0] C_GUARD_LAST = 4'(GUARD - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SET_P = 2'd1,
      ST_CLR_P = 2'd2,
      ST_GUARD = 2'd3
   } state_t;

   // Bit 0 carries the set path, bit 1 the clear path.
   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       deb_q, deb_d, deb_dly_q;
   logic [1:0][7:0]  dcnt_q, dcnt_d;
   logic [1:0]       pend_q, pend_d, consume, rise;
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             s_d, r_d, busy_d, conflict_d;
`ifdef SR_STATE_TRACK_EN
   logic             model_q, model_d;
`endif

   always_comb begin
      deb_d  = deb_q;
      dcnt_d = dcnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            dcnt_d[i] = 8'd0;
         end else if (dcnt_q[i] >= C_DEB) begin
            deb_d[i]  = sync2_q[i];
            dcnt_d[i] = 8'd0;
         end else if (dcnt_q[i] != 8'hFF) begin
            dcnt_d[i] = dcnt_q[i] + 8'd1;
         end
      end
   end

   assign rise = deb_q & ~deb_dly_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      consume    = 2'b00;
      conflict_d = 1'b0;
`ifdef SR_STATE_TRACK_EN
      model_d    = model_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = 4'd0;
            if (pend_q == 2'b11) begin
               // Clear wins; the set request is discarded along with it.
               conflict_d = 1'b1;
               consume    = 2'b11;
`ifdef SR_STATE_TRACK_EN
               if (model_q) begin
                  state_d = ST_CLR_P;
                  model_d = 1'b0;
               end
`else
               state_d = ST_CLR_P;
`endif
            end else if (pend_q[0]) begin
               consume[0] = 1'b1;
`ifdef SR_STATE_TRACK_EN
               if (!model_q) begin
                  state_d = ST_SET_P;
                  model_d = 1'b1;
               end
`else
               state_d = ST_SET_P;
`endif
            end else if (pend_q[1]) begin
               consume[1] = 1'b1;
`ifdef SR_STATE_TRACK_EN
               if (model_q) begin
                  state_d = ST_CLR_P;
                  model_d = 1'b0;
               end
`else
               state_d = ST_CLR_P;
`endif
            end
         end
         ST_SET_P, ST_CLR_P: begin
            if (cnt_q == C_PULSE_LAST) begin
               cnt_d   = 4'd0;
               state_d = (GUARD == 0) ? ST_IDLE : ST_GUARD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_GUARD: begin
            if (cnt_q == C_GUARD_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A rising edge arriving in the consume cycle must not be lost.
      pend_d = (pend_q & ~consume) | rise;
      s_d    = (state_d == ST_SET_P);
      r_d    = (state_d == ST_CLR_P);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 2'b00;
         sync2_q   <= 2'b00;
         deb_q     <= 2'b00;
         deb_dly_q <= 2'b00;
         dcnt_q    <= '0;
         pend_q    <= 2'b00;
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         s         <= 1'b0;
         r         <= 1'b0;
         busy      <= 1'b0;
         conflict  <= 1'b0;
`ifdef SR_STATE_TRACK_EN
         model_q   <= 1'b0;
`endif
      end else begin
         sync1_q   <= {clr_in, set_in};
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         dcnt_q    <= dcnt_d;
         pend_q    <= pend_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s         <= s_d;
         r         <= r_d;
         busy      <= busy_d;
         conflict  <= conflict_d;
`ifdef SR_STATE_TRACK_EN
         model_q   <= model_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
// ----------------------------------------------------------------------------
// tb_sr_cmd_gen : scoreboard bench for sr_cmd_gen (default parameters). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sr_cmd_gen;

   localparam int LAT = 8;    // DEB_CYCLES + 4

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic set_in = 1'b0;
   logic clr_in = 1'b0;
   logic s, r, busy, conflict;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   // Kinds: 0=s, 1=r, 2=conflict, 3=busy
   int exp_start[4][$];
   int exp_width[4][$];
   bit act[4];
   int st[4];
   int wd[4];
   string kname[4] = '{"s", "r", "conflict", "busy"};

   sr_cmd_gen dut (
      .clk(clk), .rst_n(rst_n), .set_in(set_in), .clr_in(clr_in),
      .s(s), .r(r), .busy(busy), .conflict(conflict)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act_v, input int exp_v);
      n_total++;
      if (act_v == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act_v, exp_v, cyc);
   endtask

   task automatic push(input int k, input int start, input int w);
      exp_start[k].push_back(start);
      exp_width[k].push_back(w);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Returns the number of the next rising edge; inputs driven after this settle before it.
   task automatic step_edge(output int e);
      @(negedge clk);
      #1;
      e = cyc + 1;
   endtask

   task automatic do_reset();
      set_in = 1'b0;
      clr_in = 1'b0;
      idle(2);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(3);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_s"}, int'(s), 0);
      chk({tag, "_r"}, int'(r), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_conflict"}, int'(conflict), 0);
   endtask

   // Monitor: measures every pulse on s/r/conflict/busy and pops its expectation.
   always @(negedge clk) begin
      logic [3:0] sig;
      sig = {busy, conflict, r, s};
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) act[k] = 1'b0;
      end else begin
         chk("s_and_r_exclusive", int'(s & r), 0);
         for (int k = 0; k < 4; k++) begin
            if (sig[k]) begin
               if (!act[k]) begin
                  act[k] = 1'b1;
                  st[k]  = cyc;
                  wd[k]  = 1;
               end else begin
                  wd[k]++;
               end
            end else if (act[k]) begin
               act[k] = 1'b0;
               if (exp_start[k].size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_%s_pulse: got start=%0d width=%0d, expected none",
                           kname[k], st[k], wd[k]);
               end else begin
                  chk({kname[k], "_start"}, st[k], exp_start[k].pop_front());
                  chk({kname[k], "_width"}, wd[k], exp_width[k].pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, e2;

      // Power-on reset
      #1 rst_n = 1'b0;
      idle(3);
      chk_outputs_zero("por");
      rst_n = 1'b1;
      idle(3);

      // Reset mid-pulse, then release with set_in still high
      step_edge(e);
      set_in = 1'b1;
      while (cyc < e + LAT) @(negedge clk);
      #1;
      chk("s_before_reset", int'(s), 1);
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("mid_reset");
      idle(2);
      step_edge(e);
      rst_n = 1'b1;
      push(0, e + LAT, 2);
      push(3, e + LAT, 3);
      idle(20);
      do_reset();

      // Clean set
      step_edge(e);
      set_in = 1'b1;
      push(0, e + LAT, 2);
      push(3, e + LAT, 3);
      idle(20);
      do_reset();

      // Bounce with 2-cycle high/low widths: must be filtered out
      for (int i = 0; i < 5; i++) begin
         set_in = 1'b1;
         idle(2);
         set_in = 1'b0;
         idle(2);
      end
      idle(20);
      do_reset();

      // Simultaneous set and clear
      step_edge(e);
      set_in = 1'b1;
      clr_in = 1'b1;
      push(2, e + LAT, 1);
`ifndef SR_STATE_TRACK_EN
      push(1, e + LAT, 2);
      push(3, e + LAT, 3);
`endif
      idle(20);
      do_reset();

      // Back-to-back: clear arrives while s is high
      step_edge(e);
      set_in = 1'b1;
      push(0, e + LAT, 2);
      push(3, e + LAT, 3);
      while (cyc < e + LAT) @(negedge clk);
      #1;
      e2 = cyc + 1;
      clr_in = 1'b1;
      push(1, e2 + LAT, 2);
      push(3, e2 + LAT, 3);
      idle(25);
      do_reset();

      // Two set requests then a clear request
      step_edge(e);
      set_in = 1'b1;
      push(0, e + LAT, 2);
      push(3, e + LAT, 3);
      idle(12);
      set_in = 1'b0;
      idle(12);
      step_edge(e);
      set_in = 1'b1;
`ifndef SR_STATE_TRACK_EN
      push(0, e + LAT, 2);
      push(3, e + LAT, 3);
`endif
      idle(12);
      set_in = 1'b0;
      idle(12);
      step_edge(e);
      clr_in = 1'b1;
      push(1, e + LAT, 2);
      push(3, e + LAT, 3);
      idle(25);

      // Every expected pulse must have been observed
      for (int k = 0; k < 4; k++) begin
         chk({"missing_", kname[k], "_pulses"}, exp_start[k].size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
